// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit_pkg
// Brief   : Shared constants and helpers for the branch resolve unit.
// Revision: 1.0
// ============================================================================
package branch_resolve_unit_pkg;

   localparam logic [2:0] c_PC_INCR    = 3'd4;
   localparam logic       c_PRED_TAKEN = 1'b1;

   // Table index is pc[lower+1:2]; returned zero-extended so callers slice to width.
   function automatic logic [63:0] bht_index(input logic [63:0] pc, input int lower);
      return (pc >> 2) & ((64'd1 << lower) - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_sat.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Enable-driven up counter that sticks at its maximum value.
// Revision: 1.0
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : ID predicted-taken redirect, EX mispredict flush, BHT update, stats.
// Revision: 1.0
// ============================================================================
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int LOWER = 5,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_is_branch,
   input  logic             id_is_jump,
   input  logic [PC_W-1:0]  id_pc,
   input  logic [PC_W-1:0]  id_target,
   input  logic             bht_prediction,
   input  logic             stall,
   input  logic             ex_taken,
   output logic             pred_redirect,
   output logic [PC_W-1:0]  pred_target,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             upd_en,
   output logic [LOWER-1:0] upd_addr,
   output logic             upd_taken,
   output logic             upd_jumped,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   logic             ex_valid_q,  ex_valid_d;
   logic [PC_W-1:0]  ex_pc_q,     ex_pc_d;
   logic [PC_W-1:0]  ex_target_q, ex_target_d;
   logic             ex_pred_q,   ex_pred_d;
   logic             ex_branch_q, ex_branch_d;
   logic             ex_jump_q,   ex_jump_d;

   logic             upd_en_q,     upd_en_d;
   logic [LOWER-1:0] upd_addr_q,   upd_addr_d;
   logic             upd_taken_q,  upd_taken_d;
   logic             upd_jumped_q, upd_jumped_d;

   logic             w_resolve;
   logic             w_actual;
   logic             w_mispred;
   logic [63:0]      w_idx;

   assign w_resolve = ex_valid_q & ~stall;
   assign w_actual  = ex_jump_q | ex_taken;
   assign w_mispred = w_resolve & (w_actual != ex_pred_q);
   assign w_idx     = bht_index(64'(ex_pc_q), LOWER);

   assign flush         = w_mispred;
   assign redirect_pc   = !w_mispred ? '0 :
                          w_actual   ? ex_target_q : ex_pc_q + PC_W'(c_PC_INCR);
   assign pred_redirect = id_valid & ~w_mispred &
                          (id_is_jump | (id_is_branch & (bht_prediction == c_PRED_TAKEN)));
   assign pred_target   = id_target;

   always_comb begin
      ex_valid_d  = ex_valid_q;
      ex_pc_d     = ex_pc_q;
      ex_target_d = ex_target_q;
      ex_pred_d   = ex_pred_q;
      ex_branch_d = ex_branch_q;
      ex_jump_d   = ex_jump_q;
      if (!stall) begin
         // A flushing cycle kills the ID instruction instead of promoting it.
         ex_valid_d  = id_valid & (id_is_branch | id_is_jump) & ~w_mispred;
         ex_pc_d     = id_pc;
         ex_target_d = id_target;
         ex_pred_d   = id_is_jump | (id_is_branch & (bht_prediction == c_PRED_TAKEN));
         ex_branch_d = id_is_branch;
         ex_jump_d   = id_is_jump;
      end
   end

   always_comb begin
      upd_en_d     = w_resolve;
      upd_addr_d   = upd_addr_q;
      upd_taken_d  = upd_taken_q;
      upd_jumped_d = upd_jumped_q;
      if (w_resolve) begin
         upd_addr_d   = w_idx[LOWER-1:0];
         upd_taken_d  = ex_taken & ex_branch_q;
         upd_jumped_d = ex_jump_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q   <= 1'b0;
         ex_pc_q      <= '0;
         ex_target_q  <= '0;
         ex_pred_q    <= 1'b0;
         ex_branch_q  <= 1'b0;
         ex_jump_q    <= 1'b0;
         upd_en_q     <= 1'b0;
         upd_addr_q   <= '0;
         upd_taken_q  <= 1'b0;
         upd_jumped_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_pc_q      <= ex_pc_d;
         ex_target_q  <= ex_target_d;
         ex_pred_q    <= ex_pred_d;
         ex_branch_q  <= ex_branch_d;
         ex_jump_q    <= ex_jump_d;
         upd_en_q     <= upd_en_d;
         upd_addr_q   <= upd_addr_d;
         upd_taken_q  <= upd_taken_d;
         upd_jumped_q <= upd_jumped_d;
      end
   end

   assign upd_en     = upd_en_q;
   assign upd_addr   = upd_addr_q;
   assign upd_taken  = upd_taken_q;
   assign upd_jumped = upd_jumped_q;

   sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (w_resolve),
      .cnt_o (branch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (w_mispred),
      .cnt_o (mispred_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Brief   : Scoreboard bench with a transaction-level model of the resolve unit.
// Revision: 1.0
// ============================================================================
module tb_branch_resolve_unit;

   localparam int          CNT_MAX = 65535;

   logic        clk;
   logic        rst;
   logic        id_valid, id_is_branch, id_is_jump;
   logic [31:0] id_pc, id_target;
   logic        bht_prediction, stall, ex_taken;
   logic        pred_redirect, flush, upd_en, upd_taken, upd_jumped;
   logic [31:0] pred_target, redirect_pc;
   logic [4:0]  upd_addr;
   logic [15:0] branch_cnt, mispred_cnt;

   branch_resolve_unit dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
      .id_pc(id_pc), .id_target(id_target), .bht_prediction(bht_prediction),
      .stall(stall), .ex_taken(ex_taken),
      .pred_redirect(pred_redirect), .pred_target(pred_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .upd_en(upd_en), .upd_addr(upd_addr), .upd_taken(upd_taken), .upd_jumped(upd_jumped),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { bit flush; logic [31:0] rpc; bit pr; logic [31:0] pt; } comb_t;
   typedef struct { int unsigned cyc; int unsigned addr; bit taken; bit jumped;
                    int unsigned br; int unsigned mis; } upd_t;

   comb_t q_comb[$];
   upd_t  q_upd[$];

   int n_cmp = 0;
   int n_err = 0;

   // Branch waiting for its outcome, as seen from the program's point of view.
   bit          p_valid = 0;
   logic [31:0] p_pc, p_tgt;
   bit          p_pred, p_jump, p_branch;
   int unsigned m_br = 0, m_mis = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit r, input bit v, input bit br, input bit jmp,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input bit bht, input bit st, input bit tk);
      comb_t c;
      upd_t  u;
      bit    res, act, mis;
      @(negedge clk);
      rst = r; id_valid = v; id_is_branch = br; id_is_jump = jmp;
      id_pc = pc; id_target = tgt; bht_prediction = bht; stall = st; ex_taken = tk;
      if (r) begin
         p_valid = 0; m_br = 0; m_mis = 0;
      end else begin
         res = p_valid && !st;
         act = p_jump || tk;
         mis = res && (act != p_pred);
         c.flush = mis;
         c.rpc   = !mis ? 32'h0 : (act ? p_tgt : p_pc + 32'd4);
         c.pr    = v && !mis && (jmp || (br && bht));
         c.pt    = tgt;
         q_comb.push_back(c);
         if (res) begin
            if (m_br < CNT_MAX) m_br++;
            if (mis && m_mis < CNT_MAX) m_mis++;
            u.cyc = cyc + 1; u.addr = (p_pc / 4) % 32;
            u.taken = tk && p_branch; u.jumped = p_jump;
            u.br = m_br; u.mis = m_mis;
            q_upd.push_back(u);
         end
         if (!st) begin
            p_valid = v && (br || jmp) && !mis;
            p_pc = pc; p_tgt = tgt; p_jump = jmp; p_branch = br; p_pred = jmp || bht;
         end
      end
   endtask

   task automatic idle(input bit st, input bit tk);
      step(0, 0, 0, 0, 32'h0, 32'h0, 0, st, tk);
   endtask

   // Combinational outputs, sampled mid-cycle after the driver has settled.
   initial begin
      comb_t c;
      forever begin
         @(negedge clk); #3;
         if (q_comb.size() > 0) begin
            c = q_comb.pop_front();
            chk("flush", flush, c.flush);
            chk("redirect_pc", redirect_pc, c.rpc);
            chk("pred_redirect", pred_redirect, c.pr);
            chk("pred_target", pred_target, c.pt);
         end
      end
   end

   // Registered update stream, sampled just after the clock edge.
   initial begin
      upd_t u;
      forever begin
         @(posedge clk); #1;
         if (upd_en === 1'b1) begin
            if (q_upd.size() == 0) begin
               chk("upd_en_unexpected", 1, 0);
            end else begin
               u = q_upd.pop_front();
               chk("upd_cycle", cyc, u.cyc);
               chk("upd_addr", upd_addr, u.addr);
               chk("upd_taken", upd_taken, u.taken);
               chk("upd_jumped", upd_jumped, u.jumped);
               chk("branch_cnt", branch_cnt, u.br);
               chk("mispred_cnt", mispred_cnt, u.mis);
            end
         end else if (q_upd.size() > 0 && q_upd[0].cyc <= cyc) begin
            u = q_upd.pop_front();
            chk("upd_en_missing", 0, 1);
         end
      end
   end

   initial begin
      logic [31:0] pc, tgt;
      bit          v, br, jmp;
      int          kind;
      rst = 1; id_valid = 0; id_is_branch = 0; id_is_jump = 0;
      id_pc = 0; id_target = 0; bht_prediction = 0; stall = 0; ex_taken = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(0, 0);
      @(posedge clk); #1;
      chk("rst_upd_en", upd_en, 0);
      chk("rst_upd_addr", upd_addr, 0);
      chk("rst_upd_taken", upd_taken, 0);
      chk("rst_upd_jumped", upd_jumped, 0);
      chk("rst_branch_cnt", branch_cnt, 0);
      chk("rst_mispred_cnt", mispred_cnt, 0);
      chk("rst_flush", flush, 0);
      chk("rst_redirect_pc", redirect_pc, 0);

      // Not-taken prediction, actually taken.
      step(0, 1, 1, 0, 32'h40, 32'h80, 0, 0, 0);
      idle(0, 1);
      idle(0, 0);
      // Taken prediction, actually not taken.
      step(0, 1, 1, 0, 32'h44, 32'h20, 1, 0, 0);
      idle(0, 0);
      idle(0, 0);
      // Jump with a stale not-taken prediction.
      step(0, 1, 0, 1, 32'h10, 32'h300, 0, 0, 0);
      idle(0, 0);
      idle(0, 0);
      // Branch held in EX by a three-cycle stall.
      step(0, 1, 1, 0, 32'h100, 32'h200, 1, 0, 0);
      idle(1, 1);
      idle(1, 0);
      idle(1, 1);
      idle(0, 0);
      idle(0, 0);
      // PC+4 wrap at the top of the address space.
      step(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h8, 1, 0, 0);
      idle(0, 0);
      idle(0, 0);

      for (int i = 0; i < 3000; i++) begin
         kind = $urandom_range(0, 9);
         v    = ($urandom_range(0, 3) != 0);
         br   = (kind < 6);
         jmp  = (kind >= 6 && kind < 8);
         pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         tgt  = $urandom() & 32'hFFFF_FFFC;
         step(($urandom_range(0, 99) == 0), v, br, jmp, pc, tgt,
              $urandom_range(0, 1), ($urandom_range(0, 4) == 0), $urandom_range(0, 1));
      end

      // Drive enough back-to-back jumps to push branch_cnt into saturation.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65538; i++) begin
         step(0, 1, 0, 1, ($urandom() & 32'hFFFF_FFFC), 32'h1000, 0, 0, 0);
      end
      idle(0, 0);
      idle(0, 0);
      idle(0, 0);
      @(posedge clk); #1;
      chk("sat_branch_cnt", branch_cnt, 16'hFFFF);
      chk("sat_mispred_cnt", mispred_cnt, 0);

      for (int i = 0; i < 10 && q_upd.size() > 0; i++) idle(0, 0);
      if (q_upd.size() > 0) chk("upd_drain_timeout", q_upd.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
